sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 47 ++++
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bundle of the two master request channels, the SRAM request/response pair and the status outputs.
// The arbiter connects through the slave modport; the masters-plus-SRAM environment uses the master modport.
interface sram_arbiter_if #(
    parameter int ADDRWIDTH = 13
);
    logic                 m0_valid;
    logic [ADDRWIDTH-1:0] m0_addr;
    logic [3:0]           m0_wstrb;
    logic [31:0]          m0_wdata;
    logic                 m0_ready;
    logic [31:0]          m0_rdata;

    logic                 m1_valid;
    logic [ADDRWIDTH-1:0] m1_addr;
    logic [3:0]           m1_wstrb;
    logic [31:0]          m1_wdata;
    logic                 m1_ready;
    logic [31:0]          m1_rdata;

    logic                 s_select;
    logic [3:0]           s_wstrb;
    logic [ADDRWIDTH-1:0] s_addr;
    logic [31:0]          s_wdata;
    logic                 s_ready;
    logic [31:0]          s_rdata;

    logic                 busy;
    logic                 owner;

    modport slave (
        input  m0_valid, m0_addr, m0_wstrb, m0_wdata,
        input  m1_valid, m1_addr, m1_wstrb, m1_wdata,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output s_select, s_wstrb, s_addr, s_wdata,
        input  s_ready, s_rdata,
        output busy, owner
    );

    modport master (
        output m0_valid, m0_addr, m0_wstrb, m0_wdata,
        output m1_valid, m1_addr, m1_wstrb, m1_wdata,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  s_select, s_wstrb, s_addr, s_wdata,
        output s_ready, s_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a single-port SRAM, sequenced by an IDLE/BUSY/DONE handshake.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise m0 has fixed priority.
module sram_arbiter #(
    parameter int ADDRWIDTH = 13
) (
    input logic           clk,
    input logic           reset,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 sel_q, sel_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic                 owner_q, owner_d;

    logic [1:0]           req_valid;
    logic [ADDRWIDTH-1:0] req_addr  [2];
    logic [3:0]           req_wstrb [2];
    logic [31:0]          req_wdata [2];

    logic                 grant;
    logic                 winner;
    logic                 complete;

    logic                 ready_q [2];
    logic                 ready_d [2];
    logic [31:0]          rdata_q [2];
    logic [31:0]          rdata_d [2];

    assign req_valid    = {bus.m1_valid, bus.m0_valid};
    assign req_addr[0]  = bus.m0_addr;
    assign req_addr[1]  = bus.m1_addr;
    assign req_wstrb[0] = bus.m0_wstrb;
    assign req_wstrb[1] = bus.m1_wstrb;
    assign req_wdata[0] = bus.m0_wdata;
    assign req_wdata[1] = bus.m1_wdata;

    // Requests are only looked at in IDLE, so a loser simply stays pending until then.
    assign grant = (state_q == ST_IDLE) && (|req_valid);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        winner = req_valid[1];
        if (&req_valid) begin
            winner = ~last_q;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = winner;
        end
    end

    // Reset value 1 makes m0 the first winner of a tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign winner = ~req_valid[0] & req_valid[1];
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        owner_d  = owner_q;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_BUSY;
                    sel_d   = 1'b1;
                    addr_d  = req_addr[winner];
                    wstrb_d = req_wstrb[winner];
                    wdata_d = req_wdata[winner];
                    owner_d = winner;
                    busy_d  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.s_ready) begin
                    state_d  = ST_DONE;
                    sel_d    = 1'b0;
                    complete = 1'b1;
                end
            end
            ST_DONE: begin
                // One dead cycle: stale s_ready and the finishing master's valid are ignored here.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            wstrb_q <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            localparam logic IDX = 1'(gi);

            // Read data is captured only for the owner's reads; writes leave it untouched.
            always_comb begin
                ready_d[gi] = complete && (owner_q == IDX);
                rdata_d[gi] = rdata_q[gi];
                if (complete && (owner_q == IDX) && (wstrb_q == 4'b0000)) begin
                    rdata_d[gi] = bus.s_rdata;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ready_q[gi] <= 1'b0;
                    rdata_q[gi] <= '0;
                end else begin
                    ready_q[gi] <= ready_d[gi];
                    rdata_q[gi] <= rdata_d[gi];
                end
            end
        end
    endgenerate

    assign bus.m0_ready = ready_q[0];
    assign bus.m1_ready = ready_q[1];
    assign bus.m0_rdata = rdata_q[0];
    assign bus.m1_rdata = rdata_q[1];
    assign bus.s_select = sel_q;
    assign bus.s_wstrb  = wstrb_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, two master drivers feeding a per-master scoreboard,
// and a negedge monitor checking grants, select timing, ready pulses and read data.
module tb_sram_arbiter;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDRWIDTH(AW)) bus ();
    sram_arbiter #(.ADDRWIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM model: ready one cycle after select is sampled, writes are byte-masked and survive reset.
    logic        load_en = 1'b0;
    logic [31:0] init_vals [32];
    logic [31:0] sram_mem [2048];
    logic        sram_ready_r = 1'b0;
    logic [31:0] sram_rdata_r = '0;
    assign bus.s_ready = sram_ready_r;
    assign bus.s_rdata = sram_rdata_r;

    always @(posedge clk) begin
        sram_ready_r <= bus.s_select && !sram_ready_r;
        if (load_en) begin
            for (int i = 0; i < 32; i++) sram_mem[i] <= init_vals[i];
        end else if (bus.s_select && !sram_ready_r) begin
            if (bus.s_wstrb == 4'b0000) begin
                sram_rdata_r <= sram_mem[bus.s_addr[AW-1:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.s_wstrb[b]) sram_mem[bus.s_addr[AW-1:2]][8*b +: 8] <= bus.s_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: memory image and each master's currently visible rdata, advanced in issue order.
    logic [31:0] shadow [32];
    logic [31:0] last_rd [2];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    bit          grant_log [$];

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_valid(input int m, input logic v);
        if (m == 0) bus.m0_valid = v;
        else bus.m1_valid = v;
    endtask

    task automatic issue(input int m, input logic [AW-1:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
        int          w;
        logic [31:0] e;
        bit          done;
        w = int'(addr[AW-1:2]);
        if (wstrb == 4'b0000) begin
            e = shadow[w];
        end else begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) shadow[w][8*b +: 8] = wdata[8*b +: 8];
            e = last_rd[m];
        end
        last_rd[m] = e;
        if (m == 0) begin
            exp_q0.push_back(e);
            bus.m0_addr = addr; bus.m0_wstrb = wstrb; bus.m0_wdata = wdata; bus.m0_valid = 1'b1;
        end else begin
            exp_q1.push_back(e);
            bus.m1_addr = addr; bus.m1_wstrb = wstrb; bus.m1_wdata = wdata; bus.m1_valid = 1'b1;
        end
        done = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if ((m == 0 && bus.m0_ready) || (m == 1 && bus.m1_ready)) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk($sformatf("m%0d_ready_timeout", m), 64'd0, 64'd1);
    endtask

    // Monitor state: previous-cycle samples plus cycle count since the last grant.
    logic        busy_p = 1'b0, rst_p = 1'b0;
    logic        v_p [2] = '{1'b0, 1'b0};
    logic [AW-1:0] addr_p [2];
    logic [3:0]  wstrb_p [2];
    logic [31:0] wdata_p [2];
    int          gcnt = 0;
    bit          exp_owner = 1'b0;
    bit          last_g = 1'b1;
    logic [31:0] cur_rd [2] = '{32'd0, 32'd0};

    always @(negedge clk) begin
        logic        rdy [2];
        logic [31:0] rdv [2];
        logic [31:0] e;
        bit          win;
        rdy[0] = bus.m0_ready; rdy[1] = bus.m1_ready;
        rdv[0] = bus.m0_rdata; rdv[1] = bus.m1_rdata;
        if (rst_p) begin
            chk("reset_outputs", {bus.m0_ready, bus.m1_ready, bus.s_select, bus.busy, bus.owner,
                                  bus.s_wstrb, bus.s_addr, bus.s_wdata}, 64'd0);
            chk("reset_rdata", {rdv[0], rdv[1]}, 64'd0);
            gcnt = 0; last_g = 1'b1; cur_rd[0] = '0; cur_rd[1] = '0;
        end else begin
            if (!busy_p) begin
                if (v_p[0] || v_p[1]) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    win = (v_p[0] && v_p[1]) ? ~last_g : v_p[1] && !v_p[0];
`else
                    win = v_p[1] && !v_p[0];
`endif
                    last_g = win;
                    chk("grant", {bus.busy, bus.owner, bus.s_select, bus.s_wstrb, bus.s_addr, bus.s_wdata},
                        {1'b1, win, 1'b1, wstrb_p[win], addr_p[win], wdata_p[win]});
                    grant_log.push_back(win);
                    exp_owner = win;
                    gcnt = 1;
                end else begin
                    chk("idle_no_grant", {bus.busy, bus.s_select}, 64'd0);
                    gcnt = 0;
                end
            end else if (gcnt > 0) begin
                gcnt++;
            end
            chk("s_select", bus.s_select, (gcnt == 1 || gcnt == 2) ? 64'd1 : 64'd0);
            if (gcnt == 4) chk("busy_clear", bus.busy, 64'd0);
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("m%0d_ready", m), rdy[m], (gcnt == 3 && exp_owner == m[0]) ? 64'd1 : 64'd0);
                if (rdy[m]) begin
                    if ((m == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        chk($sformatf("m%0d_unexpected_ready", m), 64'd1, 64'd0);
                    end else begin
                        e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        cur_rd[m] = e;
                        chk($sformatf("m%0d_rdata", m), rdv[m], e);
                    end
                end else begin
                    chk($sformatf("m%0d_rdata_hold", m), rdv[m], cur_rd[m]);
                end
            end
        end
        busy_p = bus.busy; rst_p = reset;
        v_p[0] = bus.m0_valid; v_p[1] = bus.m1_valid;
        addr_p[0] = bus.m0_addr; addr_p[1] = bus.m1_addr;
        wstrb_p[0] = bus.m0_wstrb; wstrb_p[1] = bus.m1_wstrb;
        wdata_p[0] = bus.m0_wdata; wdata_p[1] = bus.m1_wdata;
    end

    task automatic rd_burst(input int m);
        for (int k = 0; k < 4; k++) issue(m, AW'((m * 16 + k) * 4), 4'b0000, 32'd0);
        set_valid(m, 1'b0);
    endtask

    task automatic rand_master(input int m);
        int       gap;
        logic [3:0] ws;
        for (int k = 0; k < 30; k++) begin
            ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            issue(m, AW'((m * 16 + int'($urandom_range(0, 15))) * 4), ws, $urandom);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                set_valid(m, 1'b0);
                wait_cycles(gap);
            end
        end
        set_valid(m, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_wstrb = '0; bus.m0_wdata = '0;
        bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_wstrb = '0; bus.m1_wdata = '0;
        for (int i = 0; i < 32; i++) init_vals[i] = $urandom;
        init_vals[4] = 32'hDEADBEEF;
        init_vals[8] = 32'h0000_0000;
        for (int i = 0; i < 32; i++) shadow[i] = init_vals[i];
        last_rd[0] = '0; last_rd[1] = '0;
        load_en = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        load_en = 1'b0;
        wait_cycles(2);

        // m0 read of preloaded word 4
        issue(0, 13'h010, 4'b0000, 32'd0);
        bus.m0_valid = 1'b0;
        chk("m0_read_deadbeef", bus.m0_rdata, 32'hDEADBEEF);
        wait_cycles(3);

        // m1 partial write to word 8
        issue(1, 13'h020, 4'b0101, 32'h11223344);
        bus.m1_valid = 1'b0;
        wait_cycles(3);
        chk("mem8_after_write", sram_mem[8], 32'h00220044);

        // reset in the third cycle of an m0 read aborts it
        bus.m0_addr = 13'h010; bus.m0_wstrb = 4'b0000; bus.m0_valid = 1'b1;
        wait_cycles(2);
        reset = 1'b1;
        bus.m0_valid = 1'b0;
        wait_cycles(1);
        reset = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;

        // both masters reading back-to-back, starting in the first cycle after reset
        grant_log.delete();
        fork
            rd_burst(0);
            rd_burst(1);
        join
        chk("grant_log_len", 64'(grant_log.size() >= 4), 64'd1);
        if (grant_log.size() >= 4) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            chk("grant_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 64'b0101);
`else
            chk("grant_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 64'b0000);
`endif
        end
        wait_cycles(2);

        fork
            rand_master(0);
            rand_master(1);
        join
        wait_cycles(10);
        chk("scoreboard_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
